// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle for apb_req_arbiter.
// The arbiter uses the master modport; the APB slave/interconnect uses slave.
interface apb_req_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Optional ACCESS timeout abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [2*NREQ-1:0]  req_cmd_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    req_gnt_o,
    output logic [NREQ-1:0]    req_done_o,
    output logic [DW-1:0]      req_rdata_o,
    output logic               req_err_o,
    apb_req_arbiter_if.master  apb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_ptr_nx;
    logic            w_any;
    logic            w_grant;
    logic            w_cpl;
    logic            w_tmo;
    logic [NREQ-1:0] w_valid;
    logic            r_pwrite;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [NREQ-1:0] r_done;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    // READ (01) and WRITE (11) both have bit 0 set; 00 and 10 are NOPs
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_valid[i] = req_cmd_i[2*i];
        end
    end

    // Round-robin search: first valid requester at or above the pointer
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_any && w_valid[idx]) begin
                w_any = 1'b1;
                w_win = PW'(idx);
            end
        end
    end

    assign w_ptr_nx = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
    assign w_grant  = (r_state == S_IDLE) && w_any && !preset;
    assign w_cpl    = (r_state == S_ACCESS) && apb.pready_i;
    assign w_tmo    = TO_EN && (r_state == S_ACCESS) && !apb.pready_i
                      && (r_cnt == CW'(TIMEOUT - 1));

    // Combinational one-hot grant in the arbitration cycle
    always_comb begin
        req_gnt_o = '0;
        if (w_grant) begin
            req_gnt_o[w_win] = 1'b1;
        end
    end

    // Next-state logic for the APB phase sequencer
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:   if (w_any) w_state_nx = S_SETUP;
            S_SETUP:  w_state_nx = S_ACCESS;
            S_ACCESS: if (w_cpl || w_tmo) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Capture the winning request and advance the pointer at the grant
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_pwrite <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_grant) begin
            r_ptr    <= w_ptr_nx;
            r_owner  <= w_win;
            r_pwrite <= req_cmd_i[2*w_win+1];
            r_addr   <= req_addr_i[w_win*AW +: AW];
            r_wdata  <= req_wdata_i[w_win*DW +: DW];
        end
    end

    // Completion: one-cycle done pulse, read data and error status
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_cpl || w_tmo) begin
                r_done[r_owner] <= 1'b1;
            end
            if (w_cpl) begin
                r_err <= apb.pslverr_i;
                if (!r_pwrite) begin
                    r_rdata <= apb.prdata_i;
                end
            end else if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    // ACCESS cycle counter, cleared in SETUP so it restarts per transfer
    always_ff @(posedge pclk) begin
        if (preset || r_state == S_SETUP) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS && r_cnt != CW'(TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign apb.psel_o    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign apb.penable_o = (r_state == S_ACCESS);
    assign apb.pwrite_o  = r_pwrite;
    assign apb.paddr_o   = apb.psel_o ? r_addr : '0;
    assign apb.pwdata_o  = apb.psel_o ? r_wdata : '0;
    assign req_done_o    = r_done;
    assign req_rdata_o   = r_rdata;
    assign req_err_o     = r_err;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Testbench for apb_req_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_apb_req_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic [2*NREQ-1:0] req_cmd_i;
    logic [NREQ*AW-1:0] req_addr_i;
    logic [NREQ*DW-1:0] req_wdata_i;
    logic [NREQ-1:0]   req_gnt_o;
    logic [NREQ-1:0]   req_done_o;
    logic [DW-1:0]     req_rdata_o;
    logic              req_err_o;

    apb_req_arbiter_if #(.AW(AW), .DW(DW)) apb ();

    apb_req_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .req_cmd_i   (req_cmd_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_gnt_o   (req_gnt_o),
        .req_done_o  (req_done_o),
        .req_rdata_o (req_rdata_o),
        .req_err_o   (req_err_o),
        .apb         (apb)
    );

    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [1:0]  tb_cmd [NREQ];
    logic [31:0] tb_addr[NREQ];
    logic [31:0] tb_wd  [NREQ];

    // Reference model: one outstanding transaction, age counted from grant
    bit          m_act;
    int          m_age;
    int          m_own;
    int          m_ptr;
    bit          m_wr;
    logic [31:0] m_addr, m_wd, m_rdata;
    bit          m_err;
    logic [3:0]  m_done;
    logic [3:0]  e_gnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy,
                         input logic serr, input logic [31:0] rdat);
        preset        = rst;
        apb.pready_i  = rdy;
        apb.pslverr_i = serr;
        apb.prdata_i  = rdat;
        for (int i = 0; i < NREQ; i++) begin
            req_cmd_i[2*i +: 2]    = tb_cmd[i];
            req_addr_i[i*AW +: AW] = tb_addr[i];
            req_wdata_i[i*DW +: DW] = tb_wd[i];
        end
    endtask

    // Drive one cycle, compare every output with the model, advance model
    task automatic apply(input logic rst, input logic rdy,
                         input logic serr, input logic [31:0] rdat);
        int w;
        int idx;
        drive(rst, rdy, serr, rdat);
        #1;
        e_gnt = '0;
        w = -1;
        if (!m_act && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (w < 0 && (tb_cmd[idx] == 2'b01 || tb_cmd[idx] == 2'b11))
                    w = idx;
            end
        end
        if (w >= 0) e_gnt[w] = 1'b1;
        chk("gnt", 32'(req_gnt_o), 32'(e_gnt));
        chk("psel", 32'(apb.psel_o), 32'(m_act));
        chk("penable", 32'(apb.penable_o), 32'(m_act && m_age >= 2));
        chk("paddr", apb.paddr_o, m_act ? m_addr : 32'h0);
        chk("pwdata", apb.pwdata_o, m_act ? m_wd : 32'h0);
        chk("pwrite", 32'(apb.pwrite_o), 32'(m_wr));
        chk("done", 32'(req_done_o), 32'(m_done));
        chk("rdata", req_rdata_o, m_rdata);
        chk("err", 32'(req_err_o), 32'(m_err));
        m_done = '0;
        if (rst) begin
            m_act = 0; m_ptr = 0; m_wr = 0; m_rdata = '0; m_err = 0;
        end else if (w >= 0) begin
            m_act  = 1;
            m_age  = 1;
            m_own  = w;
            m_wr   = (tb_cmd[w] == 2'b11);
            m_addr = tb_addr[w];
            m_wd   = tb_wd[w];
            m_ptr  = (w + 1) % NREQ;
        end else if (m_act) begin
            if (m_age >= 2 && rdy) begin
                m_done[m_own] = 1'b1;
                m_err = serr;
                if (!m_wr) m_rdata = rdat;
                m_act = 0;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (m_age - 1 == TMO) begin
                m_done[m_own] = 1'b1;
                m_err = 1;
                m_act = 0;
            end
`endif
            else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic rst, input logic rdy,
                        input logic serr, input logic [31:0] rdat);
        apply(rst, rdy, serr, rdat);
        tick();
    endtask

    task automatic clear_cmds();
        for (int i = 0; i < NREQ; i++) tb_cmd[i] = 2'b00;
    endtask

    typedef struct {
        logic        rst;
        logic [7:0]  cmd;
        logic        rdy;
        logic [31:0] rdat;
        logic [3:0]  gnt;
        logic        psel;
        logic        pen;
        logic [31:0] paddr;
        logic [3:0]  done;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tv[8];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gq[$];
        int gc[$];
        int dn;
        logic [3:0] g;

        tv[0] = '{1, 8'h00, 0, 32'h0,    4'h0, 0, 0, 32'h0,    4'h0, 32'h0,    0};
        tv[1] = '{0, 8'h00, 0, 32'h0,    4'h0, 0, 0, 32'h0,    4'h0, 32'h0,    0};
        tv[2] = '{0, 8'h01, 0, 32'h0,    4'h1, 0, 0, 32'h0,    4'h0, 32'h0,    0};
        tv[3] = '{0, 8'h00, 0, 32'h0,    4'h0, 1, 0, 32'hA000, 4'h0, 32'h0,    0};
        tv[4] = '{0, 8'h00, 1, 32'h1234, 4'h0, 1, 1, 32'hA000, 4'h0, 32'h0,    0};
        tv[5] = '{0, 8'h00, 0, 32'h0,    4'h0, 0, 0, 32'h0,    4'h1, 32'h1234, 0};
        tv[6] = '{0, 8'hAA, 0, 32'h0,    4'h0, 0, 0, 32'h0,    4'h0, 32'h1234, 0};
        tv[7] = '{0, 8'hAA, 0, 32'h0,    4'h0, 0, 0, 32'h0,    4'h0, 32'h1234, 0};

        for (int i = 0; i < NREQ; i++) begin
            tb_cmd[i]  = 2'b00;
            tb_addr[i] = 32'hA000 + 32'(i) * 32'h100;
            tb_wd[i]   = 32'hD000_0000 + 32'(i);
        end
        m_act = 0; m_ptr = 0; m_wr = 0; m_rdata = '0; m_err = 0;
        m_done = '0; m_age = 0; m_own = 0; m_addr = '0; m_wd = '0;
        drive(1, 0, 0, 32'h0);
        @(posedge pclk);
        #1;

        // Directed vector table: reset, single read, 2'b10 encodings
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NREQ; i++) tb_cmd[i] = tv[v].cmd[2*i +: 2];
            apply(tv[v].rst, tv[v].rdy, 1'b0, tv[v].rdat);
            chk("tv_gnt", 32'(req_gnt_o), 32'(tv[v].gnt));
            chk("tv_psel", 32'(apb.psel_o), 32'(tv[v].psel));
            chk("tv_pen", 32'(apb.penable_o), 32'(tv[v].pen));
            chk("tv_paddr", apb.paddr_o, tv[v].paddr);
            chk("tv_done", 32'(req_done_o), 32'(tv[v].done));
            chk("tv_rdata", req_rdata_o, tv[v].rdata);
            chk("tv_err", 32'(req_err_o), 32'(tv[v].err));
            tick();
        end

        // Contention: all four WRITE held continuously
        clear_cmds();
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < NREQ; i++) begin
            tb_cmd[i]  = 2'b11;
            tb_addr[i] = 32'hB000 + 32'(i) * 32'h10;
            tb_wd[i]   = 32'hC0DE_0000 + 32'(i);
        end
        for (int n = 0; n < 15; n++) begin
            apply(0, 1, 0, 32'h0);
            for (int i = 0; i < NREQ; i++) begin
                if (e_gnt[i]) begin
                    gq.push_back(i);
                    gc.push_back(n);
                end
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) begin
                chk("cont_order", 32'(gq[k]), 32'(k % NREQ));
                if (k > 0) chk("cont_space", 32'(gc[k] - gc[k-1]), 32'd3);
            end else begin
                chk("cont_count", 32'(gq.size()), 32'd5);
            end
        end
        clear_cmds();
        for (int n = 0; n < 4; n++) step(0, 1, 0, 32'h0);

        // Wait states then slave error on requester 2
        step(1, 0, 0, 32'h0);
        tb_cmd[2]  = 2'b11;
        tb_addr[2] = 32'hC200;
        tb_wd[2]   = 32'h5A5A_A5A5;
        apply(0, 0, 0, 32'h0);
        chk("ws_gnt", 32'(req_gnt_o), 32'h4);
        tick();
        tb_cmd[2]  = 2'b00;
        tb_addr[2] = 32'hFFFF;
        tb_wd[2]   = 32'h0;
        step(0, 0, 0, 32'h0);
        for (int n = 0; n < 5; n++) begin
            apply(0, 0, 0, 32'h0);
            chk("ws_addr", apb.paddr_o, 32'hC200);
            chk("ws_data", apb.pwdata_o, 32'h5A5A_A5A5);
            chk("ws_pen", 32'(apb.penable_o), 32'h1);
            tick();
        end
        step(0, 1, 1, 32'h0);
        dn = 0;
        for (int n = 0; n < 3; n++) begin
            apply(0, 0, 0, 32'h0);
            if (req_done_o[2]) begin
                dn++;
                chk("ws_err", 32'(req_err_o), 32'h1);
            end
            tick();
        end
        chk("ws_done_cnt", 32'(dn), 32'd1);

        // Reset asserted during ACCESS
        step(1, 0, 0, 32'h0);
        tb_cmd[1]  = 2'b01;
        tb_addr[1] = 32'hD100;
        step(0, 0, 0, 32'h0);
        tb_cmd[1] = 2'b00;
        step(0, 0, 0, 32'h0);
        apply(1, 0, 0, 32'h0);
        chk("rst_in_access", 32'(apb.penable_o), 32'h1);
        tick();
        tb_cmd[0] = 2'b11;
        tb_cmd[3] = 2'b11;
        apply(0, 1, 0, 32'h0);
        chk("rst_psel", 32'(apb.psel_o), 32'h0);
        chk("rst_pen", 32'(apb.penable_o), 32'h0);
        chk("rst_done", 32'(req_done_o), 32'h0);
        chk("rst_gnt", 32'(req_gnt_o), 32'h1);
        tick();
        tb_cmd[0] = 2'b00;

`ifdef APB_ARB_TIMEOUT_EN
        // Timeout abort keeps the previous read data
        clear_cmds();
        step(1, 0, 0, 32'h0);
        tb_cmd[0] = 2'b01;
        step(0, 0, 0, 32'h0);
        tb_cmd[0] = 2'b00;
        step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'hCAFE);
        tb_cmd[1] = 2'b11;
        step(0, 0, 0, 32'h0);
        tb_cmd[1] = 2'b00;
        step(0, 0, 0, 32'h0);
        for (int n = 0; n < TMO; n++) step(0, 0, 0, 32'h0);
        apply(0, 0, 0, 32'h0);
        chk("tmo_done", 32'(req_done_o), 32'h2);
        chk("tmo_err", 32'(req_err_o), 32'h1);
        chk("tmo_rdata", req_rdata_o, 32'hCAFE);
        chk("tmo_psel", 32'(apb.psel_o), 32'h0);
        tick();
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 4) == 0, $urandom);
            g = e_gnt;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || (!tb_cmd[i][0] && $urandom_range(0, 4) == 0)) begin
                    tb_cmd[i]  = ($urandom_range(0, 1) == 0) ? 2'b00
                                 : 2'($urandom_range(0, 3));
                    tb_addr[i] = $urandom;
                    tb_wd[i]   = $urandom;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares one APB master port between `NREQ` local requesters. It accepts NOP/READ/WRITE commands using the same 2-bit encoding as the add-style master. It sequences the APB IDLE → SETUP → ACCESS protocol for each granted request and returns completion, read data and error status to the granted requester. It sits between the local command sources and the APB interconnect.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 16: maximum ACCESS cycles before abort. Used only with `APB_ARB_TIMEOUT_EN`.

Ports:
- `pclk` in 1: clock.
- `preset` in 1: reset. Synchronous, active-high.
- `req_cmd_i` in 2*NREQ: per-requester command. 2'b00 NOP, 2'b01 READ, 2'b11 WRITE; 2'b10 is treated as NOP.
- `req_addr_i` in NREQ*AW: per-requester address.
- `req_wdata_i` in NREQ*DW: per-requester write data.
- `req_gnt_o` out NREQ: one-hot pulse, request accepted.
- `req_done_o` out NREQ: one-hot pulse, transfer finished.
- `req_rdata_o` out DW: read data, shared by all requesters.
- `req_err_o` out 1: error status, valid with `req_done_o`.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB control.
- `paddr_o` out AW: APB address.
- `pwdata_o` out DW: APB write data.
- `prdata_i` in DW: APB read data.
- `pready_i` in 1: APB ready.
- `pslverr_i` in 1: APB slave error.

## Operation
- Requester contract: hold `req_cmd_i`, address and write data stable until `req_gnt_o[i]` is seen. Values may change after the grant.
- State machine states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when any requester is non-NOP.
  - SETUP → ACCESS unconditionally.
  - ACCESS → IDLE on `pready_i`, or on timeout when `APB_ARB_TIMEOUT_EN` is defined.
  - Illegal state encoding → IDLE.
- Arbitration runs only in IDLE and is round-robin.
  - Pointer `ptr` resets to 0.
  - Winner is the first non-NOP requester at or after `ptr`, searching upward modulo NREQ.
  - After granting i, `ptr` becomes (i+1) mod NREQ.
  - Requesters that are not granted keep waiting; no request is dropped.
- At the grant edge, the arbiter registers the owner index, `pwrite` (= cmd[1]), address and write data.
- APB outputs:
  - `psel_o` = SETUP | ACCESS; `penable_o` = ACCESS.
  - `paddr_o` and `pwdata_o` carry the registered values while `psel_o`=1 and are 0 otherwise.
  - `pwrite_o` holds its registered value and is 0 after reset.
- Completion on an ACCESS cycle with `pready_i`=1:
  - For a read, `req_rdata_o` captures `prdata_i`; for a write, `req_rdata_o` is unchanged.
  - `req_err_o` captures `pslverr_i`.
  - `req_done_o[owner]` pulses for exactly one cycle.
- Reset values: all outputs are 0, state is IDLE, `ptr`=0.
- Reset asserted mid-transfer: at that edge `psel_o`/`penable_o` drop to 0 and no `req_done_o` is issued. The requester must reissue.

## Timing
- `req_gnt_o` is combinational. It is high in the IDLE cycle in which the winner is selected, cycle T.
- T+1: SETUP (`psel_o`=1, `penable_o`=0).
- T+2: first ACCESS cycle.
- Completion registered from ACCESS cycle C:
  - `req_done_o`, `req_rdata_o` and `req_err_o` are valid in cycle C+1.
  - Cycle C+1 is IDLE and may grant the next request.
- Minimum throughput: one transfer per 3 cycles.
- Wait states: each cycle with `pready_i`=0 in ACCESS extends the transfer by one cycle. Address, data and control stay stable.
- `req_rdata_o` holds its value until the next read completes.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- When defined:
  - A counter clears on entry to ACCESS and counts ACCESS cycles.
  - If the TIMEOUT-th ACCESS cycle still has `pready_i`=0, the transfer aborts. State goes to IDLE, `req_done_o[owner]` pulses with `req_err_o`=1, and `req_rdata_o` is unchanged.
  - `pready_i` in the TIMEOUT-th cycle counts as a normal completion.
- When not defined: ACCESS waits indefinitely for `pready_i`, and `req_err_o` reflects only `pslverr_i`.

## Test plan
- Single read:
  - Stimulus: req0 READ addr 0xA000; `pready_i`=1 on the first ACCESS cycle; `prdata_i`=0x1234.
  - Response: gnt0 at T; SETUP T+1; ACCESS T+2; done0 at T+3; `req_rdata_o`=0x1234; `req_err_o`=0.
- Contention:
  - Stimulus: req0..req3 all WRITE, held continuously.
  - Response: grants in order 0,1,2,3,0, spaced 3 cycles apart; `pwdata_o` matches each owner's data.
- Wait states and error:
  - Stimulus: req2 WRITE with `pready_i` low for 5 ACCESS cycles, then high together with `pslverr_i`=1.
  - Response: address and data stable throughout; done2 pulses once with `req_err_o`=1.
- Timeout (macro defined, TIMEOUT=16):
  - Stimulus: `pready_i` held at 0.
  - Response: abort after 16 ACCESS cycles; done pulses with err=1; previous `req_rdata_o` retained.
- Reset mid-ACCESS:
  - Stimulus: assert `preset` during an ACCESS cycle.
  - Response: next cycle `psel_o`=`penable_o`=0, no done, `ptr`=0; requester 0 wins the next arbitration.
- Encoding 2'b10 on all requesters:
  - Response: no grant; stays in IDLE.
